// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU sequencing stage.
package alu_seq_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned OPC_W_DEF = 3;
    localparam int unsigned CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Command sequencer feeding a combinational ALU: repeats one opcode on an accumulator.
// Optional macro ALU_SEQ_EARLY_EXIT_EN ends a command early on a zero ALU result.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPC_W = OPC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [OPC_W-1:0] cmd_opc,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_c,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_c,
    output logic [OPC_W-1:0] alu_opc,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic [WIDTH-1:0] acc,
    output logic             res_valid,
    output logic             res_zer,
    output logic             res_neg,
    output logic [CNT_W-1:0] res_iter
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             zer_q, zer_d;
    logic             neg_q, neg_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             last_iter;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_W'(1)) || alu_zer;
`else
    assign last_iter = (cnt_q == CNT_W'(1));
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        c_d     = c_q;
        opc_d   = opc_q;
        zer_d   = zer_q;
        neg_d   = neg_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    iter_d = '0;
                    if (cmd_load) begin
                        acc_d   = cmd_b;
                        zer_d   = (cmd_b == '0);
                        neg_d   = cmd_b[WIDTH-1];
                        state_d = ST_DONE;
                    end else begin
                        opc_d   = cmd_opc;
                        b_d     = cmd_b;
                        c_d     = cmd_c;
                        cnt_d   = (cmd_rep == '0) ? CNT_W'(1) : cmd_rep;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                acc_d  = alu_w;
                zer_d  = alu_zer;
                neg_d  = alu_neg;
                iter_d = iter_q + CNT_W'(1);
                cnt_d  = cnt_q - CNT_W'(1);
                if (last_iter) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the pulse lines up with the DONE state
        valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            opc_q   <= '0;
            zer_q   <= 1'b0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            iter_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            c_q     <= c_d;
            opc_q   <= opc_d;
            zer_q   <= zer_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
            iter_q  <= iter_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_c     = c_q;
    assign alu_opc   = opc_q;
    assign acc       = acc_q;
    assign res_valid = valid_q;
    assign res_zer   = zer_q;
    assign res_neg   = neg_q;
    assign res_iter  = iter_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural stub ALU.
module tb_alu_seq_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPC_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] acc;
        logic             zer;
        logic             neg;
        logic [CNT_W-1:0] iter;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_load = 1'b0;
    logic [OPC_W-1:0] cmd_opc = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic             cmd_c = 1'b0;
    logic [CNT_W-1:0] cmd_rep = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_w, acc;
    logic             alu_c, alu_zer, alu_neg;
    logic [OPC_W-1:0] alu_opc;
    logic             res_valid, res_zer, res_neg;
    logic [CNT_W-1:0] res_iter;

    int               n_total = 0;
    int               n_bad   = 0;
    exp_t             sb[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] model_acc = '0;

    alu_seq_ctrl #(.WIDTH(WIDTH), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_opc(cmd_opc), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_rep(cmd_rep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_opc(alu_opc),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .acc(acc), .res_valid(res_valid), .res_zer(res_zer),
        .res_neg(res_neg), .res_iter(res_iter)
    );

    always #5 clk = ~clk;

    // Stub ALU: opc 0 = A+B+C, opc 1 = A-B, others pass A
    always_comb begin
        case (alu_opc)
            3'd0:    alu_w = alu_a + alu_b + {15'd0, alu_c};
            3'd1:    alu_w = alu_a - alu_b;
            default: alu_w = alu_a;
        endcase
        alu_zer = (alu_w == '0);
        alu_neg = alu_w[WIDTH-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_alu(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic c, input logic [OPC_W-1:0] opc);
        int unsigned r;
        if (opc == 3'd0) r = (int'(a) + int'(b) + int'(c)) % 65536;
        else if (opc == 3'd1) r = (int'(a) - int'(b) + 65536) % 65536;
        else r = int'(a);
        return r[WIDTH-1:0];
    endfunction

    // Monitor: every result pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                check("unexpected res_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res acc",  32'(acc),      32'(mon_e.acc));
                check("res zer",  32'(res_zer),  32'(mon_e.zer));
                check("res neg",  32'(res_neg),  32'(mon_e.neg));
                check("res iter", 32'(res_iter), 32'(mon_e.iter));
            end
        end
    end

    task automatic send(input string tag, input logic load, input logic [OPC_W-1:0] opc,
                        input logic [WIDTH-1:0] b, input logic c, input logic [CNT_W-1:0] rep);
        logic [WIDTH-1:0] traj[$];
        logic [WIDTH-1:0] a;
        exp_t e;
        int   n, k, exp_lat;
        if (load) begin
            a = b;
        end else begin
            n = (rep == 0) ? 1 : int'(rep);
            a = model_acc;
            for (int i = 0; i < n; i++) begin
                a = model_alu(a, b, c, opc);
                traj.push_back(a);
`ifdef ALU_SEQ_EARLY_EXIT_EN
                if (a == '0) break;
`endif
            end
        end
        e.acc = a;
        e.zer = (a == '0);
        e.neg = a[WIDTH-1];
        e.iter = CNT_W'(traj.size());
        exp_lat = traj.size() + 1;
        model_acc = a;

        @(negedge clk);
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_load = load; cmd_opc = opc;
        cmd_b = b; cmd_c = c; cmd_rep = rep;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_load  = 1'($urandom);
        cmd_b     = 16'($urandom);
        cmd_rep   = 4'($urandom);
        for (k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (res_valid) break;
            check({tag, " busy"}, 32'(cmd_ready), 32'd0);
            if (k >= 2 && (k - 2) < traj.size())
                check({tag, " acc step"}, 32'(acc), 32'(traj[k-2]));
        end
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        @(negedge clk);
        check({tag, " pulse len"}, 32'(res_valid), 32'd0);
        check({tag, " ready after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst acc", 32'(acc), 32'd0);
        check("rst valid", 32'(res_valid), 32'd0);
        check("rst ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready post rst", 32'(cmd_ready), 32'd1);

        send("ld8000", 1'b1, 3'd0, 16'h8000, 1'b0, 4'd0);
        send("ld5",    1'b1, 3'd0, 16'd5,    1'b0, 4'd0);
        send("add4",   1'b0, 3'd0, 16'd3,    1'b1, 4'd4);
        send("ld6",    1'b1, 3'd0, 16'd6,    1'b0, 4'd0);
        send("sub5",   1'b0, 3'd1, 16'd2,    1'b0, 4'd5);
        send("ld7",    1'b1, 3'd0, 16'd7,    1'b0, 4'd0);
        send("rep0",   1'b0, 3'd0, 16'd1,    1'b0, 4'd0);
        send("rep15",  1'b0, 3'd0, 16'd1,    1'b0, 4'd15);

        // Abort a long command with reset in its second EXEC cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_opc = 3'd0;
        cmd_b = 16'd1; cmd_c = 1'b0; cmd_rep = 4'd15;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort acc", 32'(acc), 32'd0);
        check("abort valid", 32'(res_valid), 32'd0);
        check("abort iter", 32'(res_iter), 32'd0);
        check("abort ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        model_acc = '0;
        send("post abort", 1'b0, 3'd0, 16'd5, 1'b0, 4'd1);

        repeat (3) @(negedge clk);
        check("sb empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing stage directly upstream of the 16-bit ALU (inA/inB/inC/opc -> outW/zer/neg). It accepts commands over a valid/ready handshake and holds an accumulator that drives ALU inA. Each command runs one opcode 1..N times, writing outW back into the accumulator every cycle, then reports the result and the zer/neg flags. It is opcode-agnostic and treats the ALU as purely combinational.

Parameters:
WIDTH, 16, datapath width (ALU inA/inB/outW)
OPC_W, 3, ALU opcode width
CNT_W, 4, repeat-count width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_load  in  1  1 = load accumulator with cmd_b; 0 = execute ALU op
cmd_opc  in  OPC_W  ALU opcode
cmd_b  in  WIDTH  operand B, or load value
cmd_c  in  1  ALU carry-in
cmd_rep  in  CNT_W  iteration count; 0 is treated as 1
alu_a  out  WIDTH  to ALU inA; always equals acc
alu_b  out  WIDTH  to ALU inB (latched)
alu_c  out  1  to ALU inC (latched)
alu_opc  out  OPC_W  to ALU opc (latched)
alu_w  in  WIDTH  from ALU outW
alu_zer  in  1  from ALU zer
alu_neg  in  1  from ALU neg
acc  out  WIDTH  accumulator register
res_valid  out  1  one-cycle pulse: command finished
res_zer  out  1  registered zero flag of the last result
res_neg  out  1  registered negative flag of the last result
res_iter  out  CNT_W  iterations actually executed

Behaviour:
- Reset: state IDLE; acc, alu_b, alu_c, alu_opc, res_zer, res_neg, res_iter and the counter all 0; res_valid 0. cmd_ready is 0 while rst is high.
- cmd_ready = (state==IDLE) && !rst. It is combinational from state.
- A command is accepted on the rising edge where cmd_valid && cmd_ready.
- States: IDLE, EXEC, DONE.
- IDLE with an accepted load: acc<=cmd_b, res_zer<=(cmd_b==0), res_neg<=cmd_b[WIDTH-1], res_iter<=0. Next state is DONE.
- IDLE with an accepted op: latch alu_opc<=cmd_opc, alu_b<=cmd_b, alu_c<=cmd_c. Load cnt<=(cmd_rep==0 ? 1 : cmd_rep) and clear res_iter. Next state is EXEC.
- EXEC, every cycle: acc<=alu_w, res_zer<=alu_zer, res_neg<=alu_neg, res_iter<=res_iter+1, cnt<=cnt-1. When cnt==1, go to DONE; otherwise stay in EXEC.
- alu_c is held for all iterations. The carry is not chained.
- DONE: res_valid=1 for exactly this one cycle, then IDLE. No command is accepted in DONE.
- Latency, op: accept edge, then rep EXEC cycles, then res_valid in the following cycle, i.e. rep+1 cycles after accept. Load: res_valid in the cycle after accept.
- res_* and acc hold their values in IDLE until the next command updates them.
- Back-to-back: the earliest next accept is the cycle after DONE. Throughput is one command per rep+2 cycles.
- Reset mid-EXEC or in DONE: abort immediately. There is no res_valid pulse and all registers return to their reset values.
- cmd_rep = 2^CNT_W-1 (15) must run exactly 15 iterations. The counter must not wrap.
- cmd_* inputs are ignored when no accept occurs.

Optional Feature:
- Macro ALU_SEQ_EARLY_EXIT_EN.
- Defined: in EXEC, when alu_zer==1 the result is still captured, then the state moves to DONE regardless of cnt. res_iter reflects the iterations actually run.
- Not defined: alu_zer never shortens a command; exactly max(cmd_rep,1) iterations run.

Decomposition:
- Package alu_seq_pkg: state enum (IDLE/EXEC/DONE) and WIDTH/OPC_W/CNT_W defaults.
- No sub-module is needed. The ALU is instantiated next to this block at the level above, not inside it.
- The bench connects a behavioural stub ALU: opc 0 = A+B+C, opc 1 = A-B, zer = (W==0), neg = W[15].

Test Plan:
- Reset: hold rst high 2 cycles, then check acc=0, res_valid=0, cmd_ready=0 during rst. After rst falls, cmd_ready=1 in the next cycle.
- Load 16'h8000 -> next cycle res_valid=1, acc=16'h8000, res_neg=1, res_zer=0, res_iter=0.
- After load 5: op opc0, b=3, c=1, rep=4 -> EXEC for 4 cycles, acc sequence 9,13,17,21. res_valid in the 5th cycle after accept, res_iter=4, cmd_ready low throughout.
- After load 6: op opc1, b=2, rep=5 -> acc ends 16'hFFFC, res_neg=1, res_iter=5. With ALU_SEQ_EARLY_EXIT_EN: stops at acc=0 with res_zer=1, res_iter=3.
- rep=0 with opc0, b=1, from acc=7 -> exactly one iteration, acc=8, res_iter=1.
- rst asserted in the 2nd EXEC cycle of a rep=15 command -> no res_valid, acc=0 on the next cycle, and a new command is accepted right after reset.
